// File: rtl/alt_vipcts131_common_pkg.sv
// rtl/alt_vipcts131_common_pkg.sv - shared types and helpers for the vipcts131 common blocks
// Purpose: serializer state enum and the sample-width helper.
// Ports: none (package).
package alt_vipcts131_common_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      SEND  = 1'b1
   } ser_state_t;

   // Width of one whole pixel sample, all colour planes side by side.
   function automatic int sample_width(input int bits_per_symbol, input int number_of_colour_planes);
      return bits_per_symbol * number_of_colour_planes;
   endfunction

endpackage

// File: rtl/alt_vipcts131_common_sample_serializer_if.sv
// rtl/alt_vipcts131_common_sample_serializer_if.sv - sample-in / plane-beat-out handshake bundle
// Purpose: groups the input sample handshake and the output beat handshake of the serializer.
// Ports (signals): din_valid, din_ready, din_data, din_eop, dout_valid, dout_ready, dout_data,
//                  dout_eop, start_of_sample, sample_ticks.
// Modports: slave = serializer view, master = environment view.
interface alt_vipcts131_common_sample_serializer_if #(
   parameter int NUMBER_OF_COLOUR_PLANES     = 3,
   parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2,
   parameter int BITS_PER_SYMBOL             = 8
);
   localparam int SW = alt_vipcts131_common_pkg::sample_width(BITS_PER_SYMBOL, NUMBER_OF_COLOUR_PLANES);

   logic                                    din_valid;
   logic                                    din_ready;
   logic [SW-1:0]                           din_data;
   logic                                    din_eop;
   logic                                    dout_valid;
   logic                                    dout_ready;
   logic [SW-1:0]                           dout_data;
   logic                                    dout_eop;
   logic                                    start_of_sample;
   logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks;

   modport slave (
      input  din_valid, din_data, din_eop, dout_ready,
      output din_ready, dout_valid, dout_data, dout_eop, start_of_sample, sample_ticks
   );

   modport master (
      output din_valid, din_data, din_eop, dout_ready,
      input  din_ready, dout_valid, dout_data, dout_eop, start_of_sample, sample_ticks
   );

endinterface

// File: rtl/alt_vipcts131_common_skid_buffer.sv
// rtl/alt_vipcts131_common_skid_buffer.sv - single-entry valid/ready register slice
// Purpose: breaks the combinational ready path; in_ready depends only on local state and clr.
// Ports: clk, clr (sync clear), in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream).
module alt_vipcts131_common_skid_buffer #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);
   logic              full;
   logic [DATA_W-1:0] hold_data;

   assign in_ready  = !full && !clr;
   // Empty: pass straight through so first-beat latency is unchanged.
   assign out_valid = full || in_valid;
   assign out_data  = full ? hold_data : in_data;

   always_ff @(posedge clk) begin
      if (clr) begin
         full      <= 1'b0;
         hold_data <= '0;
      end else if (full) begin
         if (out_ready)
            full <= 1'b0;
      end else if (in_valid && !out_ready) begin
         // Downstream refused the pass-through; park it here.
         full      <= 1'b1;
         hold_data <= in_data;
      end
   end

endmodule

// File: rtl/alt_vipcts131_common_sample_serializer.sv
// rtl/alt_vipcts131_common_sample_serializer.sv - whole-sample to colour-plane beat serializer
// Purpose: accepts one pixel sample per handshake, emits one plane per beat (hd_sdn=0)
//          or the whole sample in one beat (hd_sdn=1), with plane index and sample start flags.
// Ports: clk, rst (sync active-high), sclr (sync clear), hd_sdn (mode, latched per sample),
//        bus (slave modport: din_* sample input, dout_* beat output, start_of_sample, sample_ticks).
// Config: ALT_VIPCTS_SAMPLE_SERIALIZER_SKID_EN adds an input skid register so din_ready is
//         decoupled from dout_ready.
module alt_vipcts131_common_sample_serializer
   import alt_vipcts131_common_pkg::*;
#(
   parameter int NUMBER_OF_COLOUR_PLANES      = 3,
   parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2,
   parameter int BITS_PER_SYMBOL              = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic sclr,
   input  logic hd_sdn,
   alt_vipcts131_common_sample_serializer_if.slave bus
);
   localparam int SW = sample_width(BITS_PER_SYMBOL, NUMBER_OF_COLOUR_PLANES);
   localparam int L  = LOG2_NUMBER_OF_COLOUR_PLANES;

   logic          clr;
   logic          core_valid;
   logic          core_ready;
   logic [SW-1:0] core_data;
   logic          core_eop;
   logic          core_hd;

   assign clr = rst | sclr;

`ifdef ALT_VIPCTS_SAMPLE_SERIALIZER_SKID_EN
   logic [SW+1:0] skid_out;

   alt_vipcts131_common_skid_buffer #(.DATA_W(SW + 2)) u_skid (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (bus.din_valid),
      .in_ready  (bus.din_ready),
      .in_data   ({hd_sdn, bus.din_eop, bus.din_data}),
      .out_valid (core_valid),
      .out_ready (core_ready),
      .out_data  (skid_out)
   );

   assign core_data = skid_out[SW-1:0];
   assign core_eop  = skid_out[SW];
   assign core_hd   = skid_out[SW+1];
`else
   assign core_valid    = bus.din_valid;
   assign core_data     = bus.din_data;
   assign core_eop      = bus.din_eop;
   assign core_hd       = hd_sdn;
   assign bus.din_ready = core_ready;
`endif

   ser_state_t                 state;
   logic [SW-1:0]              data_r;
   logic                       eop_r;
   logic                       hd_r;
   logic [L-1:0]               idx;
   logic                       last_beat;
   logic                       out_xfer;
   logic                       accept;
   logic [BITS_PER_SYMBOL-1:0] plane;

   // With one plane idx is always 0 == N-1, so sequential degenerates to parallel.
   assign last_beat  = hd_r || (idx == L'(NUMBER_OF_COLOUR_PLANES - 1));
   assign out_xfer   = (state == SEND) && bus.dout_ready;
   assign core_ready = !clr && ((state == EMPTY) || (last_beat && bus.dout_ready));
   assign accept     = core_valid && core_ready;

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= EMPTY;
         idx    <= '0;
         data_r <= '0;
         eop_r  <= 1'b0;
         hd_r   <= 1'b0;
      end else if (accept) begin
         // Covers both EMPTY load and back-to-back reload on the last beat.
         state  <= SEND;
         idx    <= '0;
         data_r <= core_data;
         eop_r  <= core_eop;
         hd_r   <= core_hd;
      end else if (out_xfer) begin
         if (last_beat) begin
            state <= EMPTY;
            idx   <= '0;
         end else begin
            idx <= idx + L'(1);
         end
      end
   end

   assign plane               = data_r[int'(idx) * BITS_PER_SYMBOL +: BITS_PER_SYMBOL];
   assign bus.dout_valid      = (state == SEND);
   assign bus.dout_data       = hd_r ? data_r : SW'(plane);
   assign bus.dout_eop        = (state == SEND) && eop_r && last_beat;
   assign bus.start_of_sample = hd_r || (idx == '0);
   assign bus.sample_ticks    = hd_r ? '0 : idx;

endmodule

// File: tb/tb_alt_vipcts131_common_sample_serializer.sv
// tb/tb_alt_vipcts131_common_sample_serializer.sv - directed and randomized-ready bench for the sample serializer
module tb_alt_vipcts131_common_sample_serializer;

   logic clk;
   logic rst;
   logic sclr;
   logic hd_sdn;

   int n_checks = 0;
   int n_pass   = 0;

   alt_vipcts131_common_sample_serializer_if #(
      .NUMBER_OF_COLOUR_PLANES(3), .LOG2_NUMBER_OF_COLOUR_PLANES(2), .BITS_PER_SYMBOL(8)
   ) bus ();

   alt_vipcts131_common_sample_serializer #(
      .NUMBER_OF_COLOUR_PLANES(3), .LOG2_NUMBER_OF_COLOUR_PLANES(2), .BITS_PER_SYMBOL(8)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sclr   (sclr),
      .hd_sdn (hd_sdn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_beat(input string tag, input logic v, input logic [23:0] d,
                           input logic [1:0] t, input logic s, input logic e);
      check({tag, "_valid"}, bus.dout_valid, v);
      check({tag, "_data"}, bus.dout_data, d);
      check({tag, "_ticks"}, bus.sample_ticks, t);
      check({tag, "_sos"}, bus.start_of_sample, s);
      check({tag, "_eop"}, bus.dout_eop, e);
   endtask

   logic [23:0] exp_seq [6];
   logic [23:0] hd_samp [4];
   logic [23:0] exp_q [$];

   initial begin
      int sent;
      int cycles;
      bit pending;
      logic r0;
      logic [23:0] exp_d;

      exp_seq[0] = 24'h11; exp_seq[1] = 24'h22; exp_seq[2] = 24'h33;
      exp_seq[3] = 24'h44; exp_seq[4] = 24'h55; exp_seq[5] = 24'h66;
      hd_samp[0] = 24'hAABBCC; hd_samp[1] = 24'h010203;
      hd_samp[2] = 24'hF0E1D2; hd_samp[3] = 24'h5A5A5A;

      rst = 1'b1; sclr = 1'b0; hd_sdn = 1'b0;
      bus.din_valid = 1'b0; bus.din_data = '0; bus.din_eop = 1'b0; bus.dout_ready = 1'b1;

      // Reset behaviour
      tick();
      bus.din_valid = 1'b1;
      #1;
      check("rst_din_ready", bus.din_ready, 1'b0);
      check("rst_dout_valid", bus.dout_valid, 1'b0);
      bus.din_valid = 1'b0;
      rst = 1'b0;
      tick();
      check("rst_after_din_ready", bus.din_ready, 1'b1);
      chk_beat("rst_state", 1'b0, 24'h0, 2'd0, 1'b1, 1'b0);

      // Sequential back-to-back samples
      hd_sdn = 1'b0; bus.dout_ready = 1'b1;
      bus.din_valid = 1'b1; bus.din_data = 24'h332211;
      #1;
      check("seq_c0_din_ready", bus.din_ready, 1'b1);
      check("seq_c0_valid", bus.dout_valid, 1'b0);
      tick();
      bus.din_data = 24'h665544;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) bus.din_valid = 1'b0;
         #1;
         chk_beat($sformatf("seq_b%0d", i), 1'b1, exp_seq[i], 2'(i % 3), (i % 3) == 0, 1'b0);
`ifndef ALT_VIPCTS_SAMPLE_SERIALIZER_SKID_EN
         check($sformatf("seq_b%0d_din_ready", i), bus.din_ready, (i % 3) == 2);
`endif
         tick();
      end
      check("seq_idle_valid", bus.dout_valid, 1'b0);

      // Parallel mode, one beat per sample
      hd_sdn = 1'b1;
      bus.din_valid = 1'b1; bus.din_data = hd_samp[0];
      #1;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) bus.din_data = hd_samp[i + 1];
         else bus.din_valid = 1'b0;
         #1;
         chk_beat($sformatf("hd_b%0d", i), 1'b1, hd_samp[i], 2'd0, 1'b1, 1'b0);
         check($sformatf("hd_b%0d_din_ready", i), bus.din_ready, 1'b1);
         tick();
      end
      check("hd_idle_valid", bus.dout_valid, 1'b0);

      // Backpressure on plane 1; mode change mid-sample must be ignored
      hd_sdn = 1'b0;
      bus.din_valid = 1'b1; bus.din_data = 24'h332211;
      tick();
      bus.din_valid = 1'b0;
      #1;
      chk_beat("bp_b0", 1'b1, 24'h11, 2'd0, 1'b1, 1'b0);
      tick();
      bus.dout_ready = 1'b0;
      hd_sdn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk_beat($sformatf("bp_hold%0d", i), 1'b1, 24'h22, 2'd1, 1'b0, 1'b0);
`ifndef ALT_VIPCTS_SAMPLE_SERIALIZER_SKID_EN
         check($sformatf("bp_hold%0d_din_ready", i), bus.din_ready, 1'b0);
`endif
         tick();
      end
      bus.dout_ready = 1'b1;
      hd_sdn = 1'b0;
      #1;
      chk_beat("bp_b1", 1'b1, 24'h22, 2'd1, 1'b0, 1'b0);
      tick();
      chk_beat("bp_b2", 1'b1, 24'h33, 2'd2, 1'b0, 1'b0);
      tick();
      check("bp_idle_valid", bus.dout_valid, 1'b0);

      // End of packet marks only the final plane
      bus.din_valid = 1'b1; bus.din_data = 24'h0A0B0C; bus.din_eop = 1'b1;
      tick();
      bus.din_valid = 1'b0; bus.din_eop = 1'b0;
      #1;
      chk_beat("eop_b0", 1'b1, 24'h0C, 2'd0, 1'b1, 1'b0);
      tick();
      chk_beat("eop_b1", 1'b1, 24'h0B, 2'd1, 1'b0, 1'b0);
      tick();
      chk_beat("eop_b2", 1'b1, 24'h0A, 2'd2, 1'b0, 1'b1);
      tick();

      // Synchronous clear during plane 1
      bus.din_valid = 1'b1; bus.din_data = 24'h332211;
      tick();
      bus.din_valid = 1'b0;
      #1;
      chk_beat("sclr_b0", 1'b1, 24'h11, 2'd0, 1'b1, 1'b0);
      tick();
      sclr = 1'b1;
      #1;
      check("sclr_din_ready", bus.din_ready, 1'b0);
      tick();
      sclr = 1'b0;
      #1;
      check("sclr_after_valid", bus.dout_valid, 1'b0);
      check("sclr_after_din_ready", bus.din_ready, 1'b1);
      bus.din_valid = 1'b1; bus.din_data = 24'h778899;
      tick();
      bus.din_valid = 1'b0;
      #1;
      chk_beat("sclr_new_b0", 1'b1, 24'h99, 2'd0, 1'b1, 1'b0);
      tick();
      chk_beat("sclr_new_b1", 1'b1, 24'h88, 2'd1, 1'b0, 1'b0);
      tick();
      chk_beat("sclr_new_b2", 1'b1, 24'h77, 2'd2, 1'b0, 1'b0);
      tick();
      check("sclr_new_idle", bus.dout_valid, 1'b0);

      // Random dout_ready with mixed modes, scoreboarded
      sent = 0; cycles = 0; pending = 1'b0;
      while ((sent < 1000 || pending || exp_q.size() > 0) && cycles < 20000) begin
         if (!pending) bus.din_valid = 1'b0;
         if (!pending && sent < 1000) begin
            bus.din_data  = 24'($urandom);
            hd_sdn        = 1'($urandom_range(0, 1));
            bus.din_valid = 1'b1;
            pending       = 1'b1;
         end
         bus.dout_ready = (sent >= 1000 && !pending) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
`ifdef ALT_VIPCTS_SAMPLE_SERIALIZER_SKID_EN
         r0 = bus.din_ready;
         bus.dout_ready = !bus.dout_ready;
         #1;
         if (bus.din_ready !== r0) check("skid_din_ready_comb", bus.din_ready, r0);
         bus.dout_ready = !bus.dout_ready;
         #1;
`endif
         if (bus.din_valid && bus.din_ready) begin
            if (hd_sdn) begin
               exp_q.push_back(bus.din_data);
            end else begin
               exp_q.push_back({16'h0, bus.din_data[7:0]});
               exp_q.push_back({16'h0, bus.din_data[15:8]});
               exp_q.push_back({16'h0, bus.din_data[23:16]});
            end
            pending = 1'b0;
            sent++;
         end
         if (bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
               check("rnd_extra_beat", 32'd1, 32'd0);
            end else begin
               exp_d = exp_q.pop_front();
               check("rnd_beat", bus.dout_data, exp_d);
            end
         end
         tick();
         cycles++;
      end
      bus.din_valid = 1'b0;
      check("rnd_samples_sent", sent, 1000);
      check("rnd_beats_left", exp_q.size(), 0);
      check("rnd_pending", pending, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
